// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: ALU function codes, jump/cmov condition codes and
// bit positions inside the {ZF,SF,OF} condition-code vector.
package y86_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int ZF_I = 2;
  localparam int SF_I = 1;
  localparam int OF_I = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational Y86-64 condition evaluator: {ZF,SF,OF} and ifun -> cnd.
// Shared with the pipelined core, so it carries no op_valid qualification.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       bad_ifun
);

  logic zf, sf, of, lt;

  assign zf = cc[ZF_I];
  assign sf = cc[SF_I];
  assign of = cc[OF_I];
  assign lt = sf ^ of;

  always_comb begin
    cnd      = 1'b0;
    bad_ifun = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  bad_ifun = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Condition-code register for the SEQ execute stage: captures ZF/SF/OF from
// the ALU on OPq, evaluates jump/cmov conditions and keeps debug state.
module cc_unit
  import y86_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_ctrl,
  input  logic             op_valid,
  input  logic             set_cc,
  input  logic             stall,
  input  logic [3:0]       ifun,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic             cnd_q,
  output logic             cnd_q_valid,
  output logic             bad_ifun,
  output logic [CNT_W-1:0] cc_updates
);

  logic       we;
  logic       a_msb, b_msb, r_msb;
  logic       of_next;
  logic [2:0] cc_next;
  logic       bad_raw;

  assign we    = op_valid & set_cc & ~stall;
  assign a_msb = alu_a[WIDTH-1];
  assign b_msb = alu_b[WIDTH-1];
  assign r_msb = alu_result[WIDTH-1];

  always_comb begin
    of_next = 1'b0;
    case (alu_ctrl)
      ALU_ADD: of_next = (a_msb == b_msb) & (r_msb != a_msb);
      ALU_SUB: of_next = (a_msb != b_msb) & (r_msb != a_msb);
      default: of_next = 1'b0;
    endcase
  end

  always_comb begin
    cc_next       = '0;
    cc_next[ZF_I] = (alu_result == '0);
    cc_next[SF_I] = r_msb;
    cc_next[OF_I] = of_next;
  end

  // Evaluated against the stored flags, so an OPq never sees its own result.
  cond_eval u_cond_eval (
    .cc       (cc),
    .ifun     (ifun),
    .cnd      (cnd),
    .bad_ifun (bad_raw)
  );

  assign bad_ifun = bad_raw & op_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc         <= CC_RESET;
      cc_updates <= '0;
    end else if (we) begin
      cc         <= cc_next;
      cc_updates <= cc_updates + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnd_q       <= 1'b0;
      cnd_q_valid <= 1'b0;
    end else if (!stall) begin
      if (op_valid && !set_cc) begin
        cnd_q       <= cnd;
        cnd_q_valid <= 1'b1;
      end else begin
        cnd_q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit, with a narrow update counter so
// that the wrap can be reached quickly.
module tb_cc_unit;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]    alu_ctrl;
  logic          op_valid, set_cc, stall;
  logic [3:0]    ifun;
  logic [2:0]    cc;
  logic          cnd, cnd_q, cnd_q_valid, bad_ifun;
  logic [CW-1:0] cc_updates;

  int checks = 0;
  int errors = 0;

  cc_unit #(.WIDTH(W), .CC_RESET(3'b100), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_ctrl    (alu_ctrl),
    .op_valid    (op_valid),
    .set_cc      (set_cc),
    .stall       (stall),
    .ifun        (ifun),
    .cc          (cc),
    .cnd         (cnd),
    .cnd_q       (cnd_q),
    .cnd_q_valid (cnd_q_valid),
    .bad_ifun    (bad_ifun),
    .cc_updates  (cc_updates)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [1:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] r, input logic v, input logic s, input logic st,
                    input logic [3:0] f);
    alu_ctrl = ctrl; alu_a = a; alu_b = b; alu_result = r;
    op_valid = v; set_cc = s; stall = st; ifun = f;
  endtask

  initial begin
    rst = 1'b1;
    op(2'b00, '0, '0, '0, 1'b0, 1'b0, 1'b0, 4'd3);
    #2;
    chk("rst_cc", 64'(cc), 64'h4);
    chk("rst_cnd_e", 64'(cnd), 64'h1);
    chk("rst_cnd_q_valid", 64'(cnd_q_valid), 64'h0);
    chk("rst_cnd_q", 64'(cnd_q), 64'h0);
    chk("rst_updates", 64'(cc_updates), 64'h0);
    ifun = 4'd4; #1;
    chk("rst_cnd_ne", 64'(cnd), 64'h0);
    @(negedge clk); rst = 1'b0;

    // ADD overflow: 0x7FFF... + 1
    op(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk("add_cc", 64'(cc), 64'h3);
    chk("add_updates", 64'(cc_updates), 64'h1);
    chk("add_cnd_q_valid", 64'(cnd_q_valid), 64'h0);
    @(negedge clk);
    op_valid = 1'b0; set_cc = 1'b0; ifun = 4'd2; #1;
    chk("add_cnd_l", 64'(cnd), 64'h0);
    ifun = 4'd1; #1;
    chk("add_cnd_le", 64'(cnd), 64'h0);

    // SUB signed compare 3 - 5
    @(negedge clk);
    op(2'b11, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk("sub_cc", 64'(cc), 64'h2);
    chk("sub_updates", 64'(cc_updates), 64'h2);
    @(negedge clk);
    set_cc = 1'b0; ifun = 4'd2; #1;
    chk("sub_cnd_l", 64'(cnd), 64'h1);
    @(posedge clk); #1;
    chk("sub_cnd_q", 64'(cnd_q), 64'h1);
    chk("sub_cnd_q_valid", 64'(cnd_q_valid), 64'h1);

    // Stall freezes flags, counter and registered condition
    @(negedge clk);
    op(2'b00, '0, '0, '0, 1'b1, 1'b1, 1'b1, 4'd3);
    @(posedge clk); #1;
    chk("stall_cc", 64'(cc), 64'h2);
    chk("stall_updates", 64'(cc_updates), 64'h2);
    chk("stall_cnd_q", 64'(cnd_q), 64'h1);
    chk("stall_cnd_q_valid", 64'(cnd_q_valid), 64'h1);

    // set_cc on a bubble is ignored; bubble clears cnd_q_valid
    @(negedge clk);
    op(2'b00, '0, '0, '0, 1'b0, 1'b1, 1'b0, 4'd3);
    @(posedge clk); #1;
    chk("bubble_cc", 64'(cc), 64'h2);
    chk("bubble_updates", 64'(cc_updates), 64'h2);
    chk("bubble_cnd_q_valid", 64'(cnd_q_valid), 64'h0);

    // AND with zero result brings flags back to 3'b100
    @(negedge clk);
    op(2'b00, 64'hF0, 64'h0F, 64'h0, 1'b1, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk("and_cc", 64'(cc), 64'h4);
    chk("and_updates", 64'(cc_updates), 64'h3);

    // XOR result 5 while testing 'e': sees the old ZF this cycle
    @(negedge clk);
    op(2'b01, 64'h6, 64'h3, 64'h5, 1'b1, 1'b1, 1'b0, 4'd3); #1;
    chk("same_cycle_cnd", 64'(cnd), 64'h1);
    @(posedge clk); #1;
    chk("xor_cc", 64'(cc), 64'h0);
    chk("xor_updates", 64'(cc_updates), 64'h4);

    // Conditions on cc=000, then an illegal ifun
    @(negedge clk);
    set_cc = 1'b0; ifun = 4'd5; #1;
    chk("zero_cnd_ge", 64'(cnd), 64'h1);
    ifun = 4'd6; #1;
    chk("zero_cnd_g", 64'(cnd), 64'h1);
    ifun = 4'd1; #1;
    chk("zero_cnd_le", 64'(cnd), 64'h0);
    ifun = 4'd9; #1;
    chk("bad_ifun_flag", 64'(bad_ifun), 64'h1);
    chk("bad_ifun_cnd", 64'(cnd), 64'h0);
    @(posedge clk); #1;
    chk("bad_cnd_q", 64'(cnd_q), 64'h0);
    chk("bad_cnd_q_valid", 64'(cnd_q_valid), 64'h1);
    @(negedge clk);
    op_valid = 1'b0; #1;
    chk("bad_ifun_bubble", 64'(bad_ifun), 64'h0);

    // SUB overflow: min - 1
    op(2'b11, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk("subov_cc", 64'(cc), 64'h1);
    @(negedge clk);
    op_valid = 1'b0; set_cc = 1'b0; ifun = 4'd2; #1;
    chk("subov_cnd_l", 64'(cnd), 64'h1);
    ifun = 4'd6; #1;
    chk("subov_cnd_g", 64'(cnd), 64'h0);

    // Async reset between edges
    #2 rst = 1'b1; #1;
    chk("arst_cc", 64'(cc), 64'h4);
    chk("arst_updates", 64'(cc_updates), 64'h0);
    chk("arst_cnd_q_valid", 64'(cnd_q_valid), 64'h0);
    #1 rst = 1'b0;

    // Counter wrap over 16 writes
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      op(2'b01, '0, '0, 64'(i), 1'b1, 1'b1, 1'b0, 4'd0);
      @(posedge clk); #1;
      if (i == 15) chk("cnt_15", 64'(cc_updates), 64'hF);
    end
    chk("cnt_wrap", 64'(cc_updates), 64'h0);
    chk("cnt_wrap_cc", 64'(cc), 64'h0);

    @(negedge clk);
    op_valid = 1'b0; set_cc = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
